pipeline_hazard_ctrl: RTL and testbench

//  Stall/flush sequencer for the 5-stage pipeline (IF, IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipeline_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Handles load-use, taken branches and multi-cycle data-memory accesses.
module pipeline_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_req,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err
);

  localparam int WC_W = $clog2(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } state_t;

  state_t           state, state_nx;
  logic [WC_W-1:0]  wait_cnt, wc_nx;
  logic [4:0]       en;
  logic             load_use;

  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

  assign pc_en    = en[4];
  assign ifid_en  = en[3];
  assign idex_en  = en[2];
  assign exmem_en = en[1];
  assign memwb_en = en[0];

  always_comb begin
    state_nx   = state;
    wc_nx      = wait_cnt;
    en         = '0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    mem_req    = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          mem_req = mem_access;
          if (mem_access && !mem_ready) begin
            state_nx = MEM_WAIT;
            wc_nx    = WC_W'(1);
          end else if (ex_branch_taken) begin
            en         = '1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            en         = 5'b00111;
            idex_flush = 1'b1;
          end else begin
            en = '1;
          end
        end
        MEM_WAIT: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            en       = '1;
            state_nx = RUN;
            wc_nx    = '0;
          end else if (wait_cnt == WC_W'(MEM_TIMEOUT - 1)) begin
            state_nx = ERROR;
          end else begin
            wc_nx = wait_cnt + WC_W'(1);
          end
        end
        ERROR: begin
          state_nx = ERROR;
        end
        default: begin
          state_nx = RUN;
          wc_nx    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wc_nx;
      if (!en[4] && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (state_nx == ERROR)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl against a cycle model.
// Runs a 16-bit and a 4-bit counter build in lockstep.
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_mem_read, ex_branch_taken;
  logic       mem_access, mem_ready;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, mem_req, err;
  logic [15:0] stall_cnt;

  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic        s_ifid_flush, s_idex_flush, s_mem_req, s_err;
  logic [3:0]  s_stall_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_req(mem_req), .stall_cnt(stall_cnt), .err(err)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
    .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .mem_req(s_mem_req), .stall_cnt(s_stall_cnt), .err(s_err)
  );

  int n_chk = 0;
  int n_bad = 0;

  // model: waiting on memory, cycles this access has stalled,
  // timed out, and total stalled cycles since reset
  bit m_wait, m_err;
  int m_waited, m_stalls;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic cyc(input bit r, input logic [4:0] rs, input logic [4:0] rt,
                     input bit mr, input logic [4:0] ert, input bit br,
                     input bit ma, input bit rdy);
    logic [4:0] e_en;
    logic [1:0] e_fl;
    logic       e_req;
    bit         lu;
    @(negedge clk);
    rst = r; id_rs = rs; id_rt = rt; ex_mem_read = mr; ex_rt = ert;
    ex_branch_taken = br; mem_access = ma; mem_ready = rdy;
    #1;
    lu    = mr && (ert != 0) && ((ert == rs) || (ert == rt));
    e_en  = 5'b00000;
    e_fl  = 2'b00;
    e_req = 1'b0;
    if (r || m_err) begin
      e_en = 5'b00000;
    end else if (m_wait) begin
      e_req = 1'b1;
      e_en  = rdy ? 5'b11111 : 5'b00000;
    end else begin
      e_req = ma;
      if (ma && !rdy)  e_en = 5'b00000;
      else if (br)     begin e_en = 5'b11111; e_fl = 2'b11; end
      else if (lu)     begin e_en = 5'b00111; e_fl = 2'b01; end
      else             e_en = 5'b11111;
    end
    chk("en", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {27'd0, e_en});
    chk("flush", {30'd0, ifid_flush, idex_flush}, {30'd0, e_fl});
    chk("mem_req", {31'd0, mem_req}, {31'd0, e_req});
    chk("stall_cnt", {16'd0, stall_cnt}, sat(m_stalls, 65535));
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("sat_en", {27'd0, s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en},
        {27'd0, e_en});
    chk("sat_misc", {29'd0, s_ifid_flush, s_idex_flush, s_mem_req},
        {29'd0, e_fl, e_req});
    chk("sat_cnt", {28'd0, s_stall_cnt}, sat(m_stalls, 15));
    chk("sat_err", {31'd0, s_err}, {31'd0, m_err});
    @(posedge clk);
    if (r) begin
      m_wait = 0; m_err = 0; m_waited = 0; m_stalls = 0;
    end else begin
      if (!e_en[4]) m_stalls++;
      if (m_err) begin
      end else if (m_wait) begin
        if (rdy) m_wait = 0;
        else begin
          m_waited++;
          if (m_waited == TMO) begin m_err = 1; m_wait = 0; end
        end
      end else if (ma && !rdy) begin
        m_wait = 1; m_waited = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int  mode;
    bit  r;
    logic rdy;
    rst = 1; id_rs = 0; id_rt = 0; ex_mem_read = 0; ex_rt = 0;
    ex_branch_taken = 0; mem_access = 0; mem_ready = 0;
    repeat (2) @(posedge clk);
    m_wait = 0; m_err = 0; m_waited = 0; m_stalls = 0;

    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    // load-use on rs, then normal flow
    cyc(0, 8, 3, 1, 8, 0, 0, 0);
    idle(2);
    // load to $0 never stalls
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    // load-use on rt
    cyc(0, 2, 9, 1, 9, 0, 0, 0);
    // branch overrides load-use
    cyc(0, 8, 0, 1, 8, 1, 0, 0);
    // zero-wait access
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    // three-cycle memory stall
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 5, 1, 1, 0);
    cyc(0, 5, 0, 1, 5, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);
    // timeout into error, counter saturation in the 4-bit build
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 22; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    // reset in the middle of a wait abandons the access
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) mode = $urandom_range(0, 2);
      r   = ($urandom_range(0, 99) < 2);
      rdy = (mode == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
      cyc(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0),
          (mode == 2) ? 1'b0 : ($urandom_range(0, 2) == 0),
          rdy);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
